// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: opcode constants, FSM state type and the J/JAL
// target helper used by the fetch pre-decode.
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    function automatic logic is_jump(input logic [WORD_W-1:0] instr);
        return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    endfunction

    // Region bits come from the address after the jump, not the jump itself.
    function automatic logic [WORD_W-1:0] j_target(input logic [WORD_W-1:0] pc,
                                                   input logic [WORD_W-1:0] instr);
        logic [WORD_W-1:0] pc4;
        pc4 = pc + 32'd4;
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} FIFO between fetch and decode; flush clears it in one edge
// and a push may land on a full FIFO only when a pop frees a slot that cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk_CPU,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [2*WORD_W-1:0]   i_push_data,
    input  logic                  i_pop,
    output logic [2*WORD_W-1:0]   o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2*WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic                w_pop;
    logic                w_push;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty && !i_flush;
    assign w_push = i_push && !i_flush && (!o_full || w_pop);

    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_CPU) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/fetch_stage_j.sv
// Instruction fetch: owns the PC, issues req/ack word reads, pre-decodes J/JAL
// for a bubble-free redirect, and buffers words for decode in fetch_fifo.
module fetch_stage_j
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic               clk_CPU,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [WORD_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [WORD_W-1:0]  imem_rdata,
    input  logic               branch_taken,
    input  logic [WORD_W-1:0]  branch_target,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [WORD_W-1:0]  inst_data,
    output logic [WORD_W-1:0]  inst_pc
);

    localparam logic [WORD_W-1:0] PC_RST = RESET_PC & ~32'h3;

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [WORD_W-1:0]   r_pc;
    logic [WORD_W-1:0]   r_tgt;
    logic [WORD_W-1:0]   w_pc_next;
    logic [WORD_W-1:0]   w_tgt_next;
    logic [WORD_W-1:0]   w_br_tgt;
    logic [WORD_W-1:0]   w_tgt_cur;
    logic [WORD_W-1:0]   w_pc_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [2*WORD_W-1:0] w_head;

    assign w_br_tgt  = branch_target & ~32'h3;
    assign w_tgt_cur = branch_taken ? w_br_tgt : r_tgt;
    assign w_pc_ack  = is_jump(imem_rdata) ? j_target(r_pc, imem_rdata) : r_pc + 32'd4;

    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // In DROP r_pc still holds the abandoned address; the redirect waits in r_tgt.
    always_ff @(posedge clk_CPU or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= PC_RST;
            r_tgt <= PC_RST;
        end else begin
            r_pc  <= w_pc_next;
            r_tgt <= w_tgt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_tgt_next   = r_tgt;
        case (r_state)
            IDLE: begin
                w_next_state = REQ;
                if (branch_taken) w_pc_next = w_br_tgt;
            end
            REQ: begin
                if (branch_taken) begin
                    if (imem_req && !imem_ack) begin
                        w_next_state = DROP;
                        w_tgt_next   = w_br_tgt;
                    end else begin
                        w_pc_next = w_br_tgt;
                    end
                end else if (imem_req && imem_ack) begin
                    w_pc_next = w_pc_ack;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    w_next_state = REQ;
                    w_pc_next    = w_tgt_cur;
                end else begin
                    w_tgt_next = w_tgt_cur;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Requesting only while a slot is free reserves it, since nothing else pushes.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        w_push    = 1'b0;
        case (r_state)
            REQ: begin
                imem_req = !w_fifo_full;
                w_push   = imem_req && imem_ack && !branch_taken;
            end
            DROP:    imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

    assign w_pop      = inst_valid && inst_ready;
    assign inst_valid = !w_fifo_empty;
    assign inst_pc    = inst_valid ? w_head[2*WORD_W-1:WORD_W] : '0;
    assign inst_data  = inst_valid ? w_head[WORD_W-1:0] : '0;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_CPU     (clk_CPU),
        .rst_n       (rst_n),
        .i_flush     (branch_taken),
        .i_push      (w_push),
        .i_push_data ({r_pc, imem_rdata}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

endmodule
